// File: rtl/seven_segment_scan_controller_if.sv
// Load interface for the seven-segment scan controller: a valid/ready handshake
// carrying one packed hex value plus its decimal points.
interface seven_segment_scan_controller_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;

  modport master (
    output load_valid,
    output digits_in,
    output dp_in,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  digits_in,
    input  dp_in,
    output load_ready
  );
endinterface

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode 7-segment digits.
// A loaded value waits in a pending buffer and moves to the displayed buffer only at
// a frame start (or at once while disabled). Each digit slot opens with BLANK_CYCLES
// of all-anodes-off to suppress ghosting.
// Optional macro SEVEN_SEGMENT_SCAN_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_segment_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  seven_segment_scan_controller_if.slave load,
  output logic [6:0]                    leds,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         anodes,
  output logic                          frame_start
);

  // Wide enough for up to 8 digits; avoids a zero-width index when NUM_DIGITS = 1.
  localparam int unsigned IdxW = 3;

  typedef enum logic [0:0] {StBlank, StOn} state_e;

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] active_digits_q, active_digits_d;
  logic [4*NUM_DIGITS-1:0] pending_digits_q, pending_digits_d;
  logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [NUM_DIGITS-1:0]   pending_dp_q, pending_dp_d;
  logic                    pending_valid_q, pending_valid_d;
  logic [6:0]              leds_q, leds_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
  logic                    frame_start_c;
  logic [3:0]              nib;
  logic                    nib_dp;
  logic                    nib_blank;
`ifdef SEVEN_SEGMENT_SCAN_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    upper_zero;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign load.load_ready = !pending_valid_q;
  // Combinational so the pulse lands in the frame's first cycle, not one late.
  assign frame_start     = frame_start_c && !reset;
  assign leds            = leds_q;
  assign dp              = dp_q;
  assign anodes          = anodes_q;

  // Next-state for buffers and slot FSM, plus the registered output values.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    idx_d            = idx_q;
    active_digits_d  = active_digits_q;
    active_dp_d      = active_dp_q;
    pending_digits_d = pending_digits_q;
    pending_dp_d     = pending_dp_q;
    pending_valid_d  = pending_valid_q;
    frame_start_c    = enable && (state_q == StBlank) && (idx_q == '0) && (cnt_q == '0);

    // Transfer and accept are exclusive: accept needs pending empty.
    if (pending_valid_q && (frame_start_c || !enable)) begin
      active_digits_d = pending_digits_q;
      active_dp_d     = pending_dp_q;
      pending_valid_d = 1'b0;
    end else if (load.load_valid && !pending_valid_q) begin
      pending_digits_d = load.digits_in;
      pending_dp_d     = load.dp_in;
      pending_valid_d  = 1'b1;
    end

    if (!enable) begin
      state_d = StBlank;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StBlank: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_WIDTH'(BLANK_CYCLES - 1)) state_d = StOn;
        end
        StOn: begin
          if (cnt_q == CNT_WIDTH'(REFRESH_DIV - 1)) begin
            cnt_d   = '0;
            state_d = StBlank;
            idx_d   = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StBlank;
      endcase
    end

`ifdef SEVEN_SEGMENT_SCAN_LEADING_ZERO_BLANK_EN
    // A digit above 0 is a leading zero when it and every higher nibble are 0.
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero   = upper_zero && (active_digits_d[4*k +: 4] == 4'h0);
      lead_zero[k] = upper_zero && (k > 0);
    end
`endif

    // Outputs reflect the state/idx being entered on this edge.
    nib       = 4'h0;
    nib_dp    = 1'b0;
    nib_blank = 1'b0;
    anodes_d  = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (state_d == StOn && idx_d == IdxW'(k)) begin
        anodes_d[k] = 1'b0;
        nib         = active_digits_d[4*k +: 4];
        nib_dp      = active_dp_d[k];
`ifdef SEVEN_SEGMENT_SCAN_LEADING_ZERO_BLANK_EN
        nib_blank   = lead_zero[k];
`endif
      end
    end
    leds_d = 7'h7F;
    dp_d   = 1'b1;
    if (state_d == StOn) begin
      leds_d = nib_blank ? 7'h7F : seg_decode(nib);
      dp_d   = ~nib_dp;
    end
  end

  // State, buffers and outputs with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StBlank;
      cnt_q            <= '0;
      idx_q            <= '0;
      active_digits_q  <= '0;
      active_dp_q      <= '0;
      pending_digits_q <= '0;
      pending_dp_q     <= '0;
      pending_valid_q  <= 1'b0;
      leds_q           <= 7'h7F;
      dp_q             <= 1'b1;
      anodes_q         <= '1;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      idx_q            <= idx_d;
      active_digits_q  <= active_digits_d;
      active_dp_q      <= active_dp_d;
      pending_digits_q <= pending_digits_d;
      pending_dp_q     <= pending_dp_d;
      pending_valid_q  <= pending_valid_d;
      leds_q           <= leds_d;
      dp_q             <= dp_d;
      anodes_q         <= anodes_d;
    end
  end

endmodule
